// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmitter state encoding
package uart_pkg;

    localparam int DATA_BITS            = 8;
    // 100 MHz / 115200 baud; the receiver uses the same constant so both ends agree.
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Terminal value of the 16-bit baud counter for a given bit period.
    function automatic logic [15:0] baud_last(input int clks_per_bit);
        return 16'(clks_per_bit - 1);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte valid/ready handshake into the transmitter
interface uart_tx_if;

    logic [uart_pkg::DATA_BITS-1:0] tx_data;
    logic                           tx_valid;
    logic                           tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   xreset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       din,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    // A write while full is dropped even if a read frees a slot this cycle.
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!xreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serial transmitter with input byte FIFO
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       xreset,
    uart_tx_if.slave   tx,
    output logic       rs_tx,
    output logic       busy
);

    localparam logic [15:0] BAUD_LAST = baud_last(CLKS_PER_BIT);
    localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;

    uart_state_e          state_q, state_d;
    logic [15:0]          baud_cnt_q, baud_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 rs_tx_q, rs_tx_d;
    logic                 busy_q, busy_d;

    logic                 push;
    logic                 pop;
    logic                 baud_done;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;

    assign tx.tx_ready = ~fifo_full;
    assign push        = tx.tx_valid & tx.tx_ready;
    assign baud_done   = (baud_cnt_q == BAUD_LAST);

    assign rs_tx = rs_tx_q;
    assign busy  = busy_q;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .xreset (xreset),
        .wr_en  (push),
        .din    (tx.tx_data),
        .rd_en  (pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // State register plus the registered line and busy outputs; reset drops any frame.
    always_ff @(posedge clk) begin
        if (!xreset) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            rs_tx_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rs_tx_q    <= rs_tx_d;
            busy_q     <= busy_d;
        end
    end

    // Next state: bit timing, shifting and FIFO pops; STOP chains straight into START.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = fifo_dout;
                    baud_cnt_d = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state; registering them lags the FSM by one cycle.
    always_comb begin
        rs_tx_d = 1'b1;
        case (state_q)
            ST_START: rs_tx_d = 1'b0;
            ST_DATA:  rs_tx_d = shift_q[0];
            default:  rs_tx_d = 1'b1;
        endcase
        busy_d = (state_q != ST_IDLE) | (fifo_count != '0);
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx with a frame-decoding monitor
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int CPB2  = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic xreset;
    logic rs_tx, busy, rs_tx2, busy2;

    int   cyc         = 0;
    int   checks      = 0;
    int   errors      = 0;
    int   frames_seen = 0;
    int   busy_fall   = -1;
    int   busy2_fall  = -1;
    logic busy_p      = 1'b0;
    logic busy2_p     = 1'b0;
    logic mon_en      = 1'b0;

    logic [7:0] exp_q[$];
    int         fs_q[$];

    uart_tx_if ifc();
    uart_tx_if ifc2();

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .xreset(xreset), .tx(ifc), .rs_tx(rs_tx), .busy(busy)
    );

    uart_tx #(.CLKS_PER_BIT(CPB2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk(clk), .xreset(xreset), .tx(ifc2), .rs_tx(rs_tx2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy_p === 1'b1 && busy === 1'b0) busy_fall <= cyc;
        if (busy2_p === 1'b1 && busy2 === 1'b0) busy2_fall <= cyc;
        busy_p  <= busy;
        busy2_p <= busy2;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, output int acc);
        int t;
        t = 0;
        ifc.tx_data  = b;
        ifc.tx_valid = 1'b1;
        while (ifc.tx_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (ifc.tx_ready !== 1'b1) begin
            chk("push_timeout", 0, 1);
            acc          = -1;
            ifc.tx_valid = 1'b0;
        end else begin
            @(negedge clk);
            acc = cyc;
            exp_q.push_back(b);
            ifc.tx_valid = 1'b0;
            ifc.tx_data  = 8'($urandom);
        end
    endtask

    task automatic wait_frames(input int n);
        int t;
        t = 0;
        while (frames_seen < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (frames_seen < n) chk("frame_timeout", frames_seen, n);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (busy !== 1'b0) chk("idle_timeout", busy, 0);
    endtask

    // Monitor: on each start bit, pop the expected byte and compare every sample of the frame.
    initial begin : monitor
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && xreset === 1'b1 && prev === 1'b1 && rs_tx === 1'b0) begin : frame
                int         start;
                int         bad;
                logic [7:0] expb;
                logic [7:0] got;
                logic [9:0] frm;
                start = cyc;
                bad   = 0;
                got   = '0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    expb = 8'h00;
                end else begin
                    expb = exp_q.pop_front();
                end
                frm = {1'b1, expb, 1'b0};
                for (int i = 0; i < 10; i++) begin
                    for (int j = 0; j < CPB; j++) begin
                        if (i != 0 || j != 0) @(negedge clk);
                        if (rs_tx !== frm[i]) bad++;
                        if (i >= 1 && i <= 8 && j == CPB / 2) got[i-1] = rs_tx;
                    end
                end
                chk("frame_shape", bad, 0);
                chk("frame_byte", got, expb);
                fs_q.push_back(start);
                frames_seen++;
            end
            prev = rs_tx;
        end
    end

    initial begin : main
        int         acc[6];
        int         a, x, f, base, viol, highs, p, n_rand;
        logic [7:0] b;
        logic [9:0] frm;
        logic       e;

        xreset        = 1'b0;
        ifc.tx_valid  = 1'b0;
        ifc.tx_data   = 8'h00;
        ifc2.tx_valid = 1'b0;
        ifc2.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_rs_tx", rs_tx, 1);
        chk("reset_tx_ready", ifc.tx_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_rs_tx_cpb2", rs_tx2, 1);
        xreset = 1'b1;

        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (rs_tx !== 1'b1 || ifc.tx_ready !== 1'b1 || busy !== 1'b0) viol++;
        end
        chk("idle_100", viol, 0);

        mon_en = 1'b1;

        push(8'h55, a);
        wait_frames(1);
        chk("latency_55", fs_q[0] - a, 2);
        repeat (2) @(negedge clk);
        chk("busy_drop_55", busy_fall - fs_q[0], 40);

        base = frames_seen;
        push(8'h41, acc[0]);
        push(8'hA5, acc[1]);
        push(8'hFF, acc[2]);
        push(8'h00, acc[3]);
        push(8'h3C, acc[4]);
        chk("burst_consecutive", acc[4] - acc[0], 4);
        chk("ready_low_full", ifc.tx_ready, 0);
        b = 8'($urandom);
        push(b, acc[5]);
        chk("held_byte_accept", acc[5] - acc[0], 42);
        wait_frames(base + 6);
        chk("burst_latency", fs_q[base] - acc[0], 2);
        for (int k = 1; k < 6; k++) begin
            chk("back_to_back_gap", fs_q[base + k] - fs_q[base + k - 1], 40);
        end
        wait_idle();

        base   = frames_seen;
        n_rand = 8;
        push(8'h07, a);
        for (int k = 0; k < n_rand; k++) begin
            repeat ($urandom_range(0, 60)) @(negedge clk);
            push(8'($urandom), a);
        end
        wait_frames(base + n_rand + 1);
        chk("queue_drained", exp_q.size(), 0);
        wait_idle();

        mon_en = 1'b0;
        repeat (2) @(negedge clk);
        push(8'hC3, a);
        push(8'($urandom), x);
        push(8'($urandom), x);
        f = a + 2;
        while (cyc < f + 16) @(negedge clk);
        frm = {1'b1, 8'hC3, 1'b0};
        e   = frm[16 / CPB];
        chk("pre_reset_level", rs_tx, e);
        xreset = 1'b0;
        @(negedge clk);
        chk("midframe_reset_rs_tx", rs_tx, 1);
        chk("midframe_reset_ready", ifc.tx_ready, 1);
        chk("midframe_reset_busy", busy, 0);
        xreset = 1'b1;
        exp_q.delete();
        viol = 0;
        repeat (80) begin
            @(negedge clk);
            if (rs_tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        chk("no_resume_after_reset", viol, 0);

        ifc2.tx_data  = 8'h80;
        ifc2.tx_valid = 1'b1;
        chk("cpb2_ready", ifc2.tx_ready, 1);
        @(negedge clk);
        a             = cyc;
        ifc2.tx_valid = 1'b0;
        frm   = {1'b1, 8'h80, 1'b0};
        viol  = 0;
        highs = 0;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            p = cyc - (a + 2);
            e = (p < 0 || p >= 10 * CPB2) ? 1'b1 : frm[p / CPB2];
            if (rs_tx2 !== e) viol++;
            if (p >= 0 && p < 10 * CPB2 && rs_tx2 === 1'b1) highs++;
        end
        chk("cpb2_frame", viol, 0);
        chk("cpb2_high_cycles", highs, 2 * CPB2);
        chk("cpb2_busy_drop", busy2_fall - (a + 2), 10 * CPB2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
